// File: rtl/core_if_pf.sv
// core_if_pf -- prefetching instruction fetch unit.
//
// Runs a single-outstanding Wishbone classic read engine that fills a
// DEPTH-entry instruction queue ahead of decode. Decode pops the queue head
// through if_valid/if_take, so bus wait states never stall the pipeline
// directly. Supports PC redirect (flush), halt, retry and error termination.
//
// Parameters:
//   DEPTH     queue entries (power of two, >= 2)
//   RESET_PC  fetch address after reset
//   RTY_MAX   consecutive retries tolerated per address (retry limit build only)
//
// Optional feature macro: CORE_IF_RTY_LIMIT_EN
//   defined   : the (RTY_MAX+1)th consecutive retry on one address is treated
//               as a fetch error
//   undefined : retries are unlimited and no retry counter exists
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   adr_o/sel_o/we_o    Wishbone address (registered), byte selects, write enable
//   cyc_o/stb_o         Wishbone cycle/strobe (registered, always equal)
//   dat_i               Wishbone read data
//   ack_i/rty_i/err_i   Wishbone terminations (priority err > rty > ack)
//   if_halt             stop issuing new requests
//   set_pc/new_pc       redirect strobe and word-aligned target
//   if_valid/if_ins/if_pc  queue head (NOP / fetch PC when empty)
//   if_take             decode consumes the head
//   if_busy             queue empty while a bus cycle is in progress
//   if_err              sticky fetch error, cleared by set_pc

`ifndef CORE_OPCODE_NOP
`define CORE_OPCODE_NOP 6'b000000
`endif

module core_if_pf #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          RTY_MAX  = 15
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] adr_o,
    output logic [3:0]  sel_o,
    output logic        we_o,
    output logic        cyc_o,
    output logic        stb_o,
    input  logic [31:0] dat_i,
    input  logic        ack_i,
    input  logic        rty_i,
    input  logic        err_i,
    input  logic        if_halt,
    input  logic        set_pc,
    input  logic [31:0] new_pc,
    output logic        if_valid,
    output logic [31:0] if_ins,
    output logic [31:0] if_pc,
    input  logic        if_take,
    output logic        if_busy,
    output logic        if_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    // Opcode occupies the top six bits of the instruction word.
    localparam logic [5:0]  NOP_OPC = `CORE_OPCODE_NOP;
    localparam logic [31:0] NOP_INS = {NOP_OPC, 26'd0};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUS     = 2'd1,
        S_RTY_GAP = 2'd2,
        S_ERR     = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     adr_q;
    logic            cyc_q;
    logic            err_q, err_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            push, pop, issue_ok;

    logic [31:0]     ins_mem [DEPTH];
    logic [31:0]     pc_mem  [DEPTH];

`ifdef CORE_IF_RTY_LIMIT_EN
    localparam int RW = (RTY_MAX > 0) ? $clog2(RTY_MAX + 1) : 1;
    logic [RW-1:0]   rty_cnt_q, rty_cnt_d;
`endif

    // ------------------------------------------------------------------
    // Queue bookkeeping. A redirect discards every response and pop in the
    // same cycle, so flush always wins.
    // ------------------------------------------------------------------
    always_comb begin
        pop      = if_take && (count_q != '0) && !set_pc;
        push     = (state_q == S_BUS) && ack_i && !rty_i && !err_i && !set_pc;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (set_pc) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
        end
        // Next-cycle occupancy already includes the word being acked, so a
        // new request is only issued when it is guaranteed a free slot.
        issue_ok = !if_halt && !set_pc && (count_d < DEPTH_C);
    end

    // ------------------------------------------------------------------
    // Bus engine next state.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        err_d   = err_q;
`ifdef CORE_IF_RTY_LIMIT_EN
        rty_cnt_d = rty_cnt_q;
`endif
        if (set_pc) begin
            state_d = S_IDLE;
            pc_d    = new_pc;
            err_d   = 1'b0;
`ifdef CORE_IF_RTY_LIMIT_EN
            rty_cnt_d = '0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (issue_ok) state_d = S_BUS;
                end
                S_BUS: begin
                    if (err_i) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else if (rty_i) begin
`ifdef CORE_IF_RTY_LIMIT_EN
                        if (rty_cnt_q == RW'(RTY_MAX)) begin
                            state_d = S_ERR;
                            err_d   = 1'b1;
                        end else begin
                            rty_cnt_d = rty_cnt_q + RW'(1);
                            state_d   = S_RTY_GAP;
                        end
`else
                        state_d = S_RTY_GAP;
`endif
                    end else if (ack_i) begin
                        pc_d    = pc_q + 32'd4;
                        state_d = issue_ok ? S_BUS : S_IDLE;
`ifdef CORE_IF_RTY_LIMIT_EN
                        rty_cnt_d = '0;
`endif
                    end
                end
                S_RTY_GAP: begin
                    // Same address is reissued; pc_q was not advanced.
                    state_d = issue_ok ? S_BUS : S_IDLE;
                end
                S_ERR: begin
                    state_d = S_ERR;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            adr_q    <= RESET_PC;
            cyc_q    <= 1'b0;
            err_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            // While a cycle is open the address always equals the fetch PC.
            adr_q    <= pc_d;
            cyc_q    <= (state_d == S_BUS);
            err_q    <= err_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef CORE_IF_RTY_LIMIT_EN
    always_ff @(posedge clk) begin
        if (rst) rty_cnt_q <= '0;
        else     rty_cnt_q <= rty_cnt_d;
    end
`endif

    // Queue storage; contents need no reset because count_q gates validity.
    always_ff @(posedge clk) begin
        if (push) begin
            ins_mem[wr_ptr_q] <= dat_i;
            pc_mem[wr_ptr_q]  <= pc_q;
        end
    end

    // ------------------------------------------------------------------
    // Outputs.
    // ------------------------------------------------------------------
    assign adr_o    = adr_q;
    assign sel_o    = 4'b1111;
    assign we_o     = 1'b0;
    assign cyc_o    = cyc_q;
    assign stb_o    = cyc_q;
    assign if_valid = (count_q != '0);
    assign if_ins   = if_valid ? ins_mem[rd_ptr_q] : NOP_INS;
    assign if_pc    = if_valid ? pc_mem[rd_ptr_q]  : pc_q;
    assign if_busy  = (count_q == '0) && cyc_q;
    assign if_err   = err_q;

endmodule

// File: tb/tb_core_if_pf.sv
// Directed testbench for core_if_pf (DEPTH=4, RESET_PC=0, RTY_MAX=2).
// The bus slave answers combinationally while cyc/stb are high; which
// termination it gives is chosen per cycle by the stimulus. Read data is a
// fixed function of the address so pushed words can be recognised.
module tb_core_if_pf;

    logic        clk;
    logic        rst;
    logic [31:0] adr_o;
    logic [3:0]  sel_o;
    logic        we_o;
    logic        cyc_o;
    logic        stb_o;
    logic [31:0] dat_i;
    logic        ack_i;
    logic        rty_i;
    logic        err_i;
    logic        if_halt;
    logic        set_pc;
    logic [31:0] new_pc;
    logic        if_valid;
    logic [31:0] if_ins;
    logic [31:0] if_pc;
    logic        if_take;
    logic        if_busy;
    logic        if_err;

    logic        ack_en, rty_en, err_en;
    int          n_checks;
    int          n_pass;

    localparam logic [31:0] NOP_INS = 32'h0000_0000;

    core_if_pf #(
        .DEPTH   (4),
        .RESET_PC(32'h0000_0000),
        .RTY_MAX (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .adr_o   (adr_o),
        .sel_o   (sel_o),
        .we_o    (we_o),
        .cyc_o   (cyc_o),
        .stb_o   (stb_o),
        .dat_i   (dat_i),
        .ack_i   (ack_i),
        .rty_i   (rty_i),
        .err_i   (err_i),
        .if_halt (if_halt),
        .set_pc  (set_pc),
        .new_pc  (new_pc),
        .if_valid(if_valid),
        .if_ins  (if_ins),
        .if_pc   (if_pc),
        .if_take (if_take),
        .if_busy (if_busy),
        .if_err  (if_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign ack_i = cyc_o & stb_o & ack_en;
    assign rty_i = cyc_o & stb_o & rty_en;
    assign err_i = cyc_o & stb_o & err_en;
    assign dat_i = word_at(adr_o);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %s: %h", tag, got);
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one cycle; outputs are sampled and inputs driven 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in cycle 0: first cycle with rst low.
    task automatic do_reset();
        rst = 1'b1; if_halt = 1'b0; set_pc = 1'b0; new_pc = '0; if_take = 1'b0;
        ack_en = 1'b0; rty_en = 1'b0; err_en = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1; if_halt = 1'b0; set_pc = 1'b0; new_pc = '0; if_take = 1'b0;
        ack_en = 1'b0; rty_en = 1'b0; err_en = 1'b0;
        tick(); tick();

        // Reset state
        check("rst_cyc",   cyc_o,    0);
        check("rst_stb",   stb_o,    0);
        check("rst_adr",   adr_o,    32'h0);
        check("rst_valid", if_valid, 0);
        check("rst_err",   if_err,   0);
        check("rst_busy",  if_busy,  0);
        check("rst_ins",   if_ins,   NOP_INS);
        check("rst_pc",    if_pc,    32'h0);
        check("rst_sel",   sel_o,    4'hF);
        check("rst_we",    we_o,     0);

        // Streaming with zero-wait slave and decode always taking
        rst = 1'b0; ack_en = 1'b1; if_take = 1'b1;
        tick();
        check("str_c1_cyc",   cyc_o,    1);
        check("str_c1_adr",   adr_o,    32'h0);
        check("str_c1_busy",  if_busy,  1);
        check("str_c1_valid", if_valid, 0);
        for (int c = 2; c <= 6; c++) begin
            tick();
            check("str_adr",   adr_o,    32'(4 * (c - 1)));
            check("str_valid", if_valid, 1);
            check("str_pc",    if_pc,    32'(4 * (c - 2)));
            check("str_ins",   if_ins,   word_at(32'(4 * (c - 2))));
        end

        // Queue fill with no pops
        do_reset(); ack_en = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            check("fill_adr", adr_o, 32'(4 * (c - 1)));
            check("fill_stb", stb_o, 1);
        end
        tick();
        check("full_stb",   stb_o,    0);
        check("full_valid", if_valid, 1);
        check("full_pc",    if_pc,    32'h0);
        tick();
        check("full_stb2", stb_o, 0);
        if_take = 1'b1;
        tick();
        if_take = 1'b0;
        check("reopen_stb", stb_o, 1);
        check("reopen_adr", adr_o, 32'h10);
        check("reopen_pc",  if_pc, 32'h4);
        tick();
        check("refull_stb", stb_o, 0);

        // Redirect during an ack (with a simultaneous take)
        do_reset(); ack_en = 1'b1;
        tick(); tick(); tick();
        check("redir_adr8", adr_o, 32'h8);
        set_pc = 1'b1; new_pc = 32'h100; if_take = 1'b1;
        tick();
        set_pc = 1'b0; if_take = 1'b0;
        check("redir_cyc",   cyc_o,    0);
        check("redir_valid", if_valid, 0);
        check("redir_pc",    if_pc,    32'h100);
        check("redir_ins",   if_ins,   NOP_INS);
        tick();
        check("redir_cyc2", cyc_o, 1);
        check("redir_adr",  adr_o, 32'h100);
        tick();
        check("redir_valid2", if_valid, 1);
        check("redir_hpc",    if_pc,    32'h100);
        check("redir_hins",   if_ins,   word_at(32'h100));

        // Error termination on 0xC
        do_reset(); ack_en = 1'b1; if_take = 1'b1;
        tick(); tick(); tick(); tick();
        check("err_adrC", adr_o, 32'hC);
        err_en = 1'b1;
        tick();
        err_en = 1'b0;
        check("err_flag",  if_err,   1);
        check("err_cyc",   cyc_o,    0);
        check("err_valid", if_valid, 0);
        check("err_pc",    if_pc,    32'hC);
        repeat (5) tick();
        check("err_hold_cyc", cyc_o,  0);
        check("err_hold",     if_err, 1);
        set_pc = 1'b1; new_pc = 32'h40;
        tick();
        set_pc = 1'b0;
        check("err_clr",     if_err, 0);
        check("err_clr_cyc", cyc_o,  0);
        tick();
        check("err_res_cyc", cyc_o, 1);
        check("err_res_adr", adr_o, 32'h40);

        // Two retries on 0x4 then ack
        do_reset(); ack_en = 1'b1;
        tick();
        tick();
        check("rty_adr4", adr_o, 32'h4);
        rty_en = 1'b1;
        tick();
        check("rty_gap1_cyc", cyc_o, 0);
        check("rty_gap1_adr", adr_o, 32'h4);
        tick();
        check("rty_re1_cyc", cyc_o, 1);
        check("rty_re1_adr", adr_o, 32'h4);
        tick();
        check("rty_gap2_cyc", cyc_o, 0);
        rty_en = 1'b0;
        tick();
        check("rty_re2_cyc", cyc_o, 1);
        check("rty_re2_adr", adr_o, 32'h4);
        tick();
        check("rty_next_adr", adr_o, 32'h8);
        check("rty_head0",    if_pc, 32'h0);
        if_take = 1'b1;
        tick();
        check("rty_head4",     if_pc,  32'h4);
        check("rty_head4_ins", if_ins, word_at(32'h4));
        tick();
        check("rty_head8", if_pc, 32'h8);

        // Three consecutive retries on one address
        do_reset(); ack_en = 1'b1; rty_en = 1'b1;
        repeat (6) tick();
        rty_en = 1'b0;
        tick();
`ifdef CORE_IF_RTY_LIMIT_EN
        check("rtylim_err", if_err, 1);
        check("rtylim_cyc", cyc_o,  0);
`else
        check("rtylim_err", if_err, 0);
        check("rtylim_cyc", cyc_o,  1);
        check("rtylim_adr", adr_o,  32'h0);
`endif

        // Halt blocks issue
        do_reset(); if_halt = 1'b1; ack_en = 1'b1;
        tick(); tick();
        check("halt_cyc", cyc_o, 0);
        if_halt = 1'b0;
        tick();
        check("unhalt_cyc", cyc_o, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
